regbus_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one register-bus target (e.g. the bootrom or clock-manager regbus port, 48-bit address, 32-bit data) between NumReq requesters. It registers the winning request toward the target and holds it until the target completes. It routes the response back to the winner only. A watchdog aborts target transactions that stall, returning an error so the requester is never hung.

---
 rtl/regbus_rr_arbiter_if.sv | 26 ++
 rtl/regbus_rr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_regbus_rr_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regbus_rr_arbiter_if.sv
// Register-bus bundle: NumReq parallel request lanes sharing one broadcast response.
// The arbiter uses the slave view toward requesters and the master view toward the target.
interface regbus_rr_arbiter_if #(
  parameter int unsigned NumReq    = 1,
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 32
);
  logic [NumReq-1:0]             valid;
  logic [NumReq-1:0]             write;
  logic [NumReq*AddrWidth-1:0]   addr;
  logic [NumReq*DataWidth-1:0]   wdata;
  logic [NumReq*DataWidth/8-1:0] wstrb;
  logic [NumReq-1:0]             ready;
  logic [DataWidth-1:0]          rdata;
  logic                          error;

  modport master (
    output valid, write, addr, wdata, wstrb,
    input  ready, rdata, error
  );

  modport slave (
    input  valid, write, addr, wdata, wstrb,
    output ready, rdata, error
  );
endinterface

// File: rtl/regbus_rr_arbiter.sv
// Round-robin arbiter sharing one register-bus target among NumReq requesters,
// with a watchdog that aborts stalled target transactions with an error response.
//
// state | meaning
// IDLE  | no transaction outstanding; grants when a request is valid and no response is being delivered
// BUSY  | winner's request registered toward the target; waits for mst ready or watchdog expiry
module regbus_rr_arbiter #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  regbus_rr_arbiter_if.slave  slv,
  regbus_rr_arbiter_if.master mst,
  output logic                busy_o,
  output logic                timeout_o
);
  localparam int unsigned IdxW  = $clog2(NumReq);
  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned WdW   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [WdW-1:0] WdLast = (TimeoutCycles > 0) ? WdW'(TimeoutCycles - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [IdxW-1:0]        win_q, win_d;
  logic [WdW-1:0]         wdog_q, wdog_d;
  logic                   mvalid_q, mvalid_d;
  logic                   mwrite_q, mwrite_d;
  logic [AddrWidth-1:0]   maddr_q, maddr_d;
  logic [DataWidth-1:0]   mwdata_q, mwdata_d;
  logic [StrbW-1:0]       mwstrb_q, mwstrb_d;
  logic [NumReq-1:0]      rready_q, rready_d;
  logic [DataWidth-1:0]   rrdata_q, rrdata_d;
  logic                   rerror_q, rerror_d;
  logic                   tout_q, tout_d;

  logic [AddrWidth-1:0]   req_addr  [NumReq];
  logic [DataWidth-1:0]   req_wdata [NumReq];
  logic [StrbW-1:0]       req_wstrb [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign req_addr[g]  = slv.addr[g*AddrWidth +: AddrWidth];
    assign req_wdata[g] = slv.wdata[g*DataWidth +: DataWidth];
    assign req_wstrb[g] = slv.wstrb[g*StrbW +: StrbW];
  end

  // Rotating priority search starting at the pointer.
  logic            grant_found;
  logic [IdxW-1:0] grant_idx;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand_idx = IdxW'((32'(ptr_q) + k) % NumReq);
      if (!grant_found && slv.valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  logic [IdxW-1:0] ptr_next;
  assign ptr_next = (win_q == IdxW'(NumReq - 1)) ? '0 : win_q + IdxW'(1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    wdog_d   = wdog_q;
    mvalid_d = mvalid_q;
    mwrite_d = mwrite_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwstrb_d = mwstrb_q;
    rready_d = '0;
    rrdata_d = rrdata_q;
    rerror_d = rerror_q;
    tout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A cycle that delivers a response never also grants.
        if (grant_found && (rready_q == '0)) begin
          win_d    = grant_idx;
          mwrite_d = slv.write[grant_idx];
          maddr_d  = req_addr[grant_idx];
          mwdata_d = req_wdata[grant_idx];
          mwstrb_d = req_wstrb[grant_idx];
          mvalid_d = 1'b1;
          wdog_d   = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        wdog_d = wdog_q + WdW'(1);
        if (mst.ready[0]) begin
          rready_d = NumReq'(1) << win_q;
          rrdata_d = mwrite_q ? '0 : mst.rdata;
          rerror_d = mst.error;
          mvalid_d = 1'b0;
          ptr_d    = ptr_next;
          state_d  = IDLE;
        end else if ((TimeoutCycles != 0) && (wdog_q == WdLast)) begin
          rready_d = NumReq'(1) << win_q;
          rrdata_d = '0;
          rerror_d = 1'b1;
          tout_d   = 1'b1;
          mvalid_d = 1'b0;
          ptr_d    = ptr_next;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      wdog_q   <= '0;
      mvalid_q <= 1'b0;
      mwrite_q <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwstrb_q <= '0;
      rready_q <= '0;
      rrdata_q <= '0;
      rerror_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      wdog_q   <= wdog_d;
      mvalid_q <= mvalid_d;
      mwrite_q <= mwrite_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwstrb_q <= mwstrb_d;
      rready_q <= rready_d;
      rrdata_q <= rrdata_d;
      rerror_q <= rerror_d;
      tout_q   <= tout_d;
    end
  end

  assign mst.valid = mvalid_q;
  assign mst.write = mwrite_q;
  assign mst.addr  = maddr_q;
  assign mst.wdata = mwdata_q;
  assign mst.wstrb = mwstrb_q;
  assign slv.ready = rready_q;
  assign slv.rdata = rrdata_q;
  assign slv.error = rerror_q;
  assign busy_o    = (state_q == BUSY);
  assign timeout_o = tout_q;
endmodule

// File: tb/tb_regbus_rr_arbiter.sv
// Bench for regbus_rr_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level reference model.
module tb_regbus_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 48;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic busy_o, timeout_o;

  always #5 clk_i = ~clk_i;

  regbus_rr_arbiter_if #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) slv_bus ();
  regbus_rr_arbiter_if #(.NumReq(1), .AddrWidth(AW), .DataWidth(DW)) mst_bus ();

  regbus_rr_arbiter #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .slv       (slv_bus),
    .mst       (mst_bus),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  // requester side
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_write = '0;
  logic [AW-1:0] req_addr  [N];
  logic [DW-1:0] req_wdata [N];
  logic [SW-1:0] req_wstrb [N];

  assign slv_bus.valid = req_valid;
  assign slv_bus.write = req_write;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign slv_bus.addr[g*AW +: AW]  = req_addr[g];
    assign slv_bus.wdata[g*DW +: DW] = req_wdata[g];
    assign slv_bus.wstrb[g*SW +: SW] = req_wstrb[g];
  end

  // target side
  logic          tgt_ready = 1'b0;
  logic [DW-1:0] tgt_rdata = '0;
  logic          tgt_error = 1'b0;
  assign mst_bus.ready = tgt_ready;
  assign mst_bus.rdata = tgt_rdata;
  assign mst_bus.error = tgt_error;

  // stimulus controls
  bit            keep_valid = 0;
  bit            rnd_req    = 0;
  int            force_wait = -1;
  bit            fix_en     = 0;
  logic [DW-1:0] fix_rdata  = '0;
  logic          fix_err    = 1'b0;

  // reference model: one outstanding transaction, owner, rotating pointer, busy age
  bit            m_busy  = 0;
  int            m_owner = 0;
  int            m_ptr   = 0;
  int            m_n     = 0;
  int            tgt_wait = 0;
  logic          e_mvalid = 0, e_write = 0, e_error = 0, e_timeout = 0;
  logic [AW-1:0] e_addr  = '0;
  logic [DW-1:0] e_wdata = '0, e_rdata = '0;
  logic [SW-1:0] e_wstrb = '0;
  logic [N-1:0]  e_ready = '0;

  int n_cmp = 0;
  int n_err = 0;
  int n_cyc = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, n_cyc);
    end
  endtask

  task automatic finish_txn(input bit aborted);
    e_ready          = '0;
    e_ready[m_owner] = 1'b1;
    e_rdata          = (aborted || e_write) ? '0 : tgt_rdata;
    e_error          = aborted ? 1'b1 : tgt_error;
    e_timeout        = aborted;
    e_mvalid         = 1'b0;
    m_busy           = 0;
    m_ptr            = (m_owner + 1) % N;
  endtask

  task automatic model_step();
    bit delivering;
    bit found;
    int idx;
    if (!rst_ni) begin
      m_busy = 0; m_ptr = 0; m_n = 0;
      e_mvalid = 0; e_write = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
      e_ready = '0; e_rdata = '0; e_error = 0; e_timeout = 0;
      return;
    end
    delivering = (e_ready != '0);
    e_ready    = '0;
    e_timeout  = 0;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && !delivering && req_valid[idx]) begin
          found   = 1;
          m_owner = idx;
        end
      end
      if (found) begin
        e_mvalid = 1'b1;
        e_write  = req_write[m_owner];
        e_addr   = req_addr[m_owner];
        e_wdata  = req_wdata[m_owner];
        e_wstrb  = req_wstrb[m_owner];
        m_busy   = 1;
        m_n      = 0;
        tgt_wait = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 10));
      end
    end else begin
      if (tgt_ready) finish_txn(0);
      else if (TO > 0 && m_n + 1 == TO) finish_txn(1);
      else m_n++;
    end
  endtask

  task automatic check_outputs();
    check_val("mst_valid", mst_bus.valid, e_mvalid);
    check_val("busy", busy_o, e_mvalid);
    check_val("timeout", timeout_o, e_timeout);
    check_val("slv_ready", slv_bus.ready, e_ready);
    check_val("slv_rdata", slv_bus.rdata, e_rdata);
    check_val("slv_error", slv_bus.error, e_error);
    if (e_mvalid) begin
      check_val("mst_write", mst_bus.write, e_write);
      check_val("mst_addr", mst_bus.addr, e_addr);
      check_val("mst_wdata", mst_bus.wdata, e_wdata);
      check_val("mst_wstrb", mst_bus.wstrb, e_wstrb);
    end
  endtask

  task automatic new_req(input int i, input bit wr);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i]  = AW'({$urandom(), $urandom()});
    req_wdata[i] = $urandom();
    req_wstrb[i] = SW'($urandom());
  endtask

  task automatic drive_target();
    if (m_busy) begin
      tgt_ready = (m_n == tgt_wait);
      tgt_rdata = fix_en ? fix_rdata : $urandom();
      tgt_error = fix_en ? fix_err : ($urandom_range(0, 3) == 0);
    end else begin
      tgt_ready = 1'($urandom_range(0, 1));
      tgt_rdata = $urandom();
      tgt_error = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_step();
    #1;
    n_cyc++;
    check_outputs();
    for (int i = 0; i < N; i++) begin
      if (e_ready[i]) begin
        req_valid[i] = 1'b0;
        if (keep_valid) new_req(i, 1'($urandom_range(0, 1)));
      end
    end
    if (rnd_req) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0) new_req(i, 1'($urandom_range(0, 1)));
    end
    drive_target();
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    req_valid = '0;
    cycle();
    rst_ni    = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", n_cyc);
    $fatal(1);
  end

  initial begin
    int owners[$];
    int times[$];
    int mv_cnt;
    bit seen;
    bit saw_to;

    for (int i = 0; i < N; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0; req_wstrb[i] = '0;
    end

    // reset state
    do_reset();
    do_reset();
    check_val("rst_mst_valid", mst_bus.valid, 0);
    check_val("rst_mst_addr", mst_bus.addr, 0);
    check_val("rst_slv_ready", slv_bus.ready, 0);
    check_val("rst_busy", busy_o, 0);

    // single read from requester 1 with a 0-wait target
    fix_en = 1; fix_rdata = 32'hCAFE_F00D; fix_err = 0; force_wait = 0;
    new_req(1, 0);
    req_addr[1] = 48'h0100_0000_0010;
    cycle();
    check_val("rd_mst_valid", mst_bus.valid, 1);
    check_val("rd_mst_addr", mst_bus.addr, 48'h0100_0000_0010);
    cycle();
    check_val("rd_slv_ready", slv_bus.ready, 4'b0010);
    check_val("rd_slv_rdata", slv_bus.rdata, 32'hCAFE_F00D);
    fix_en = 0;

    // all requesters continuously valid: fairness and pulse spacing
    do_reset();
    keep_valid = 1; force_wait = 0;
    for (int i = 0; i < N; i++) new_req(i, 1'($urandom_range(0, 1)));
    for (int c = 0; c < 40 && owners.size() < 5; c++) begin
      cycle();
      if (slv_bus.ready != '0) begin
        check_val("ord_onehot", 64'($onehot(slv_bus.ready)), 1);
        owners.push_back(onehot_idx(slv_bus.ready));
        times.push_back(n_cyc);
      end
    end
    check_val("ord_count", owners.size(), 5);
    for (int k = 0; k < owners.size(); k++) check_val("ord_owner", owners[k], k % N);
    for (int k = 1; k < times.size(); k++) check_val("ord_gap", times[k] - times[k-1], 3);
    keep_valid = 0;

    // write with strobes, target errors after 5 wait cycles
    do_reset();
    fix_en = 1; fix_rdata = 32'hDEAD_BEEF; fix_err = 1; force_wait = 5;
    new_req(3, 1);
    req_wstrb[3] = 4'b0011;
    req_wdata[3] = 32'h1234_5678;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cycle();
      if (mst_bus.valid) check_val("wr_wstrb_hold", mst_bus.wstrb, 4'b0011);
      if (slv_bus.ready != '0) begin
        seen = 1;
        check_val("wr_ready", slv_bus.ready, 4'b1000);
        check_val("wr_error", slv_bus.error, 1);
        check_val("wr_rdata", slv_bus.rdata, 0);
      end
    end
    check_val("wr_seen", seen, 1);
    fix_en = 0;

    // watchdog abort, then next requester granted
    do_reset();
    force_wait = 1000;
    new_req(0, 0);
    new_req(1, 0);
    mv_cnt = 0; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cycle();
      if (mst_bus.valid) mv_cnt++;
      if (timeout_o) begin
        seen = 1;
        check_val("to_ready", slv_bus.ready, 4'b0001);
        check_val("to_error", slv_bus.error, 1);
        check_val("to_rdata", slv_bus.rdata, 0);
      end
    end
    check_val("to_seen", seen, 1);
    check_val("to_len", mv_cnt, TO);
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      cycle();
      if (mst_bus.valid) begin
        seen = 1;
        check_val("to_next_addr", mst_bus.addr, req_addr[1]);
      end
    end
    check_val("to_next_seen", seen, 1);

    // ready arrives on the watchdog's last cycle: normal completion wins
    do_reset();
    fix_en = 1; fix_rdata = 32'hA5A5_0001; fix_err = 0; force_wait = TO - 1;
    new_req(2, 0);
    seen = 0; saw_to = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cycle();
      if (timeout_o) saw_to = 1;
      if (slv_bus.ready != '0) begin
        seen = 1;
        check_val("race_error", slv_bus.error, 0);
        check_val("race_rdata", slv_bus.rdata, 32'hA5A5_0001);
      end
    end
    check_val("race_seen", seen, 1);
    check_val("race_timeout", saw_to, 0);
    fix_en = 0;

    // reset during a stalled read
    do_reset();
    force_wait = 1000;
    new_req(0, 0);
    repeat (4) cycle();
    check_val("rmb_busy_before", busy_o, 1);
    do_reset();
    check_val("rmb_mst_valid", mst_bus.valid, 0);
    check_val("rmb_busy", busy_o, 0);
    check_val("rmb_ready", slv_bus.ready, 0);
    repeat (3) begin
      cycle();
      check_val("rmb_no_pulse", slv_bus.ready, 0);
    end
    force_wait = 0;
    new_req(2, 0);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle();
      if (slv_bus.ready != '0) begin
        seen = 1;
        check_val("rmb_req2", slv_bus.ready, 4'b0100);
      end
    end
    check_val("rmb_seen", seen, 1);

    // random traffic
    do_reset();
    force_wait = -1;
    rnd_req    = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end
    rnd_req = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
